// File: rtl/init_llr_pkg.sv
// Shared constants and types for the channel-LLR loader
// and the decoder-side channel-LLR bank readers.
package init_llr_pkg;

  localparam int DATA_W      = 11;
  localparam int ADDR_W      = 6;
  localparam int NUM_BANKS   = 10;
  localparam int FRAME_WORDS = NUM_BANKS * (2 ** ADDR_W);
  localparam int BANK_W      = $clog2(NUM_BANKS);

  typedef logic [DATA_W-1:0]    llr_t;
  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [BANK_W-1:0]    bank_t;
  typedef logic [NUM_BANKS-1:0] wren_t;

  localparam bank_t BANK_LAST = bank_t'(NUM_BANKS - 1);
  localparam addr_t ADDR_LAST = addr_t'((2 ** ADDR_W) - 1);

  // One registered bank write, as presented on the output pins.
  typedef struct packed {
    wren_t en;
    addr_t addr;
    llr_t  data;
  } bank_wr_t;

endpackage

// File: rtl/init_llr_bank_dec.sv
// Bank index plus write strobe decoded to one-hot
// channel-LLR bank write enables.
module init_llr_bank_dec
  import init_llr_pkg::*;
(
  input  bank_t bank_i,
  input  logic  stb_i,
  output wren_t en_o
);

  always_comb begin
    en_o = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      en_o[i] = stb_i && (bank_i == bank_t'(i));
    end
  end

endmodule

// File: rtl/init_llr.sv
// Channel-LLR loader: spreads a gapped LLR stream over ten
// ping-pong banks, address-major, and flags a complete frame.
module init_llr
  import init_llr_pkg::*;
(
  input  logic  wrclk,
  input  logic  reset,
  input  logic  start_read,
  input  logic  input_en,
  input  logic  frame_lock,
  input  llr_t  data_in,
  output llr_t  data_Lch,
  output addr_t wr_addr_Lch,
  output logic  wr_addr_high_Lch,
  output logic  wren_Lch_H0,
  output logic  wren_Lch_H1,
  output logic  wren_Lch_H2,
  output logic  wren_Lch_H3,
  output logic  wren_Lch_H4,
  output logic  wren_Lch_H5,
  output logic  wren_Lch_H6,
  output logic  wren_Lch_H7,
  output logic  wren_Lch_H8,
  output logic  wren_Lch_H9,
  output logic  data_ready
);

  bank_t    bank_q, bank_d;
  addr_t    addr_q, addr_d;
  bank_wr_t wr_q, wr_d;
  logic     half_q, half_d;
  logic     rdy_q, rdy_d;

  logic  accept;
  logic  last_word;
  wren_t dec_en;

  assign accept = start_read & frame_lock
                & input_en & ~rdy_q;

  assign last_word = (bank_q == BANK_LAST)
                   && (addr_q == ADDR_LAST);

  init_llr_bank_dec u_dec (
    .bank_i (bank_q),
    .stb_i  (accept),
    .en_o   (dec_en)
  );

  always_comb begin
    bank_d  = bank_q;
    addr_d  = addr_q;
    half_d  = half_q;
    rdy_d   = rdy_q;
    wr_d    = wr_q;
    wr_d.en = dec_en;

    // Losing lock restarts the frame; the half and flag are kept.
    if (!frame_lock) begin
      bank_d = '0;
      addr_d = '0;
    end else if (accept) begin
      wr_d.addr = addr_q;
      wr_d.data = data_in;
      if (last_word) begin
        bank_d = '0;
        addr_d = '0;
        rdy_d  = 1'b1;
      end else if (bank_q == BANK_LAST) begin
        bank_d = '0;
        addr_d = addr_q + addr_t'(1);
      end else begin
        bank_d = bank_q + bank_t'(1);
      end
    end

    // Consumer acknowledge: release the frame, swap halves.
    if (rdy_q && !start_read) begin
      rdy_d  = 1'b0;
      half_d = ~half_q;
    end
  end

  always_ff @(posedge wrclk) begin
    if (reset) begin
      bank_q <= '0;
      addr_q <= '0;
      half_q <= 1'b0;
      rdy_q  <= 1'b0;
      wr_q   <= '0;
    end else begin
      bank_q <= bank_d;
      addr_q <= addr_d;
      half_q <= half_d;
      rdy_q  <= rdy_d;
      wr_q   <= wr_d;
    end
  end

  assign data_Lch         = wr_q.data;
  assign wr_addr_Lch      = wr_q.addr;
  assign wr_addr_high_Lch = half_q;
  assign data_ready       = rdy_q;

  assign wren_Lch_H0 = wr_q.en[0];
  assign wren_Lch_H1 = wr_q.en[1];
  assign wren_Lch_H2 = wr_q.en[2];
  assign wren_Lch_H3 = wr_q.en[3];
  assign wren_Lch_H4 = wr_q.en[4];
  assign wren_Lch_H5 = wr_q.en[5];
  assign wren_Lch_H6 = wr_q.en[6];
  assign wren_Lch_H7 = wr_q.en[7];
  assign wren_Lch_H8 = wr_q.en[8];
  assign wren_Lch_H9 = wr_q.en[9];

endmodule

// File: tb/tb_init_llr.sv
// Bench for init_llr: word-index model checked every cycle,
// plus literal expectations on logged bank writes.
module tb_init_llr;

  logic        wrclk = 1'b0;
  logic        reset = 1'b1;
  logic        start_read = 1'b0;
  logic        input_en = 1'b0;
  logic        frame_lock = 1'b0;
  logic [10:0] data_in = '0;
  logic [10:0] data_Lch;
  logic [5:0]  wr_addr_Lch;
  logic        wr_addr_high_Lch;
  logic        data_ready;
  logic        h0, h1, h2, h3, h4, h5, h6, h7, h8, h9;
  logic [9:0]  wren;

  assign wren = {h9, h8, h7, h6, h5, h4, h3, h2, h1, h0};

  always #5 wrclk = ~wrclk;

  init_llr dut (
    .wrclk            (wrclk),
    .reset            (reset),
    .start_read       (start_read),
    .input_en         (input_en),
    .frame_lock       (frame_lock),
    .data_in          (data_in),
    .data_Lch         (data_Lch),
    .wr_addr_Lch      (wr_addr_Lch),
    .wr_addr_high_Lch (wr_addr_high_Lch),
    .wren_Lch_H0      (h0),
    .wren_Lch_H1      (h1),
    .wren_Lch_H2      (h2),
    .wren_Lch_H3      (h3),
    .wren_Lch_H4      (h4),
    .wren_Lch_H5      (h5),
    .wren_Lch_H6      (h6),
    .wren_Lch_H7      (h7),
    .wren_Lch_H8      (h8),
    .wren_Lch_H9      (h9),
    .data_ready       (data_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Model: the frame is just a count k of accepted words.
  int         k = 0;
  bit         m_rdy = 0;
  bit         m_half = 0;
  logic [9:0]  m_wren = '0;
  logic [5:0]  m_addr = '0;
  logic [10:0] m_data = '0;
  bit          m_acc, m_rdy0;

  always @(posedge wrclk) begin
    m_rdy0 = m_rdy;
    m_acc  = start_read && frame_lock && input_en && !m_rdy0;
    m_wren = '0;
    if (reset) begin
      k = 0; m_rdy = 0; m_half = 0;
      m_addr = '0; m_data = '0;
    end else begin
      if (!frame_lock) k = 0;
      else if (m_acc) begin
        m_wren[k % 10] = 1'b1;
        m_addr = 6'(k / 10);
        m_data = data_in;
        k++;
        if (k == 640) begin k = 0; m_rdy = 1; end
      end
      if (m_rdy0 && !start_read) begin
        m_rdy = 0;
        m_half = !m_half;
      end
    end
  end

  typedef struct {
    int bank; int addr; int data; int half; int rdy;
  } wr_t;
  wr_t wlog[$];

  function automatic int oh2idx(input logic [9:0] v);
    int idx = -1;
    int n = 0;
    for (int i = 0; i < 10; i++)
      if (v[i]) begin idx = i; n++; end
    return (n == 1) ? idx : -1;
  endfunction

  always @(negedge wrclk) begin
    if (chk_en) begin
      chk("wren", int'(wren), int'(m_wren));
      chk("addr", int'(wr_addr_Lch), int'(m_addr));
      chk("data", int'(data_Lch), int'(m_data));
      chk("half", int'(wr_addr_high_Lch), int'(m_half));
      chk("ready", int'(data_ready), int'(m_rdy));
      if (wren != '0)
        wlog.push_back('{oh2idx(wren), int'(wr_addr_Lch),
                         int'(data_Lch), int'(wr_addr_high_Lch),
                         int'(data_ready)});
    end
  end

  task automatic cyc(input bit en, input logic [10:0] d);
    @(negedge wrclk);
    input_en = en;
    data_in  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0);
  endtask

  task automatic feed(input int n, input int base);
    for (int i = 0; i < n; i++) cyc(1, 11'(base + i));
    idle(2);
  endtask

  task automatic ack();
    @(negedge wrclk);
    start_read = 0;
    @(negedge wrclk);
    start_read = 1;
  endtask

  task automatic chk_wr(input string nm, input int idx,
                        input int b, input int a, input int h);
    if (idx >= wlog.size()) begin
      chk({nm, "_present"}, wlog.size(), idx + 1);
    end else begin
      chk({nm, "_bank"}, wlog[idx].bank, b);
      chk({nm, "_addr"}, wlog[idx].addr, a);
      chk({nm, "_half"}, wlog[idx].half, h);
    end
  endtask

  initial begin
    repeat (2) @(posedge wrclk);
    @(negedge wrclk);
    chk_en = 1;
    chk("rst_wren", int'(wren), 0);
    chk("rst_half", int'(wr_addr_high_Lch), 0);
    chk("rst_ready", int'(data_ready), 0);
    chk("rst_addr", int'(wr_addr_Lch), 0);
    chk("rst_data", int'(data_Lch), 0);
    reset = 0;
    frame_lock = 1;
    for (int i = 0; i < 5; i++) cyc(1, 11'h7ff);
    idle(2);
    chk("disabled_writes", wlog.size(), 0);

    // Continuous frame, data = word index.
    start_read = 1;
    feed(640, 0);
    chk("f1_count", wlog.size(), 640);
    chk_wr("f1_w0", 0, 0, 0, 0);
    chk_wr("f1_w13", 13, 3, 1, 0);
    chk_wr("f1_w639", 639, 9, 63, 0);
    if (wlog.size() == 640) begin
      chk("f1_w13_data", wlog[13].data, 13);
      chk("f1_w638_rdy", wlog[638].rdy, 0);
      chk("f1_w639_rdy", wlog[639].rdy, 1);
    end
    for (int i = 0; i < 5; i++) cyc(1, 11'h123);
    idle(2);
    chk("held_writes", wlog.size(), 640);
    chk("held_ready", int'(data_ready), 1);

    ack();
    chk("ack_ready", int'(data_ready), 0);
    chk("ack_half", int'(wr_addr_high_Lch), 1);

    // Gapped frame into the other half.
    wlog.delete();
    for (int i = 0; i < 300; i++) cyc(1, 11'(3 * i));
    idle(100);
    for (int i = 300; i < 640; i++) cyc(1, 11'(3 * i));
    idle(2);
    chk("f2_count", wlog.size(), 640);
    chk_wr("f2_w0", 0, 0, 0, 1);
    chk_wr("f2_w300", 300, 0, 30, 1);
    chk_wr("f2_w639", 639, 9, 63, 1);
    if (wlog.size() == 640) begin
      chk("f2_w300_data", wlog[300].data, 900);
      chk("f2_w639_rdy", wlog[639].rdy, 1);
    end

    ack();
    chk("ack2_half", int'(wr_addr_high_Lch), 0);

    // Abort after 25 words.
    wlog.delete();
    feed(25, 0);
    @(negedge wrclk);
    frame_lock = 0;
    input_en = 1;
    repeat (3) @(negedge wrclk);
    frame_lock = 1;
    input_en = 0;
    feed(640, 100);
    chk("ab_count", wlog.size(), 665);
    chk_wr("ab_restart", 25, 0, 0, 0);
    if (wlog.size() == 665) begin
      chk("ab_restart_data", wlog[25].data, 100);
      chk("ab_w663_rdy", wlog[663].rdy, 0);
      chk("ab_w664_rdy", wlog[664].rdy, 1);
    end

    ack();
    chk("ack3_half", int'(wr_addr_high_Lch), 1);

    // Mid-frame reset.
    wlog.delete();
    feed(300, 0);
    @(negedge wrclk);
    reset = 1;
    repeat (2) @(negedge wrclk);
    reset = 0;
    chk("mr_wren", int'(wren), 0);
    chk("mr_half", int'(wr_addr_high_Lch), 0);
    chk("mr_addr", int'(wr_addr_Lch), 0);
    chk("mr_data", int'(data_Lch), 0);
    wlog.delete();
    feed(1, 55);
    chk("mr_count", wlog.size(), 1);
    chk_wr("mr_w0", 0, 0, 0, 0);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
